// File: rtl/calc_core_seq.sv
`default_nettype none
// ============================================================================
// Module      : calc_core_seq
// Description : Calculator control and datapath core. Synchronises and
//               edge-detects Enter/Clear, sequences operand A, operand B and
//               the opcode through an FSM, and runs single-cycle ALU ops plus
//               an iterative shift-add multiplier. Result and flags are held
//               for the BCD/display path.
//               Optional macro CALC_DIV_EN adds opcode 9, an unsigned
//               restoring divider that shares the multiplier's iteration
//               register.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_core_seq #(
    parameter int WIDTH       = 8,
    parameter int OP_W        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [OP_W+WIDTH-1:0] switchs,
    input  logic                  enter,
    input  logic                  clear,
    output logic [WIDTH-1:0]      a_q,
    output logic [WIDTH-1:0]      b_q,
    output logic [WIDTH-1:0]      result,
    output logic                  zero,
    output logic                  carry,
    output logic                  overflow,
    output logic                  busy,
    output logic                  result_valid,
    output logic [2:0]            state_q,
    output logic [3:0]            leds
);

    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WITH_A = 3'd1;
    localparam logic [2:0] S_WITH_B = 3'd2;
    localparam logic [2:0] S_CALC   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NOT = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SHL = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SHR = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(8);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_ent_sync;
    logic [SYNC_STAGES-1:0] r_clr_sync;
    logic                   r_ent_edge;
    logic                   r_clr_edge;
    logic                   w_ent_pulse;
    logic                   w_clr_pulse;

    logic [2:0]             r_state;
    logic [2:0]             w_state_next;

    logic [WIDTH-1:0]       w_operand;
    logic [OP_W-1:0]        w_opcode;

    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH-1:0]       r_result;
    logic                   r_zero;
    logic                   r_carry;
    logic                   r_ovf;
    logic                   r_result_valid;

    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic [WIDTH-1:0]       w_alu_res;
    logic                   w_alu_c;
    logic                   w_alu_v;
    logic                   w_op_single;
    logic                   w_op_mul;
    logic                   w_op_div;

    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     w_acc_step;
    logic [2*WIDTH-1:0]     w_mul_step;
    logic [WIDTH:0]         w_mul_sum;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_calc_last;
    logic                   w_calc_div;

    assign w_operand = switchs[WIDTH-1:0];
    assign w_opcode  = switchs[OP_W+WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Button synchronisers followed by a rising-edge register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ent_sync <= '0;
            r_clr_sync <= '0;
            r_ent_edge <= 1'b0;
            r_clr_edge <= 1'b0;
        end else begin
            r_ent_sync <= {r_ent_sync[SYNC_STAGES-2:0], enter};
            r_clr_sync <= {r_clr_sync[SYNC_STAGES-2:0], clear};
            r_ent_edge <= r_ent_sync[SYNC_STAGES-1];
            r_clr_edge <= r_clr_sync[SYNC_STAGES-1];
        end
    end

    assign w_ent_pulse = r_ent_sync[SYNC_STAGES-1] & ~r_ent_edge;
    assign w_clr_pulse = r_clr_sync[SYNC_STAGES-1] & ~r_clr_edge;

    // ------------------------------------------------------------------
    // Single-cycle ALU on the latched operands
    // ------------------------------------------------------------------
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // Decode opcode into result, carry and overflow for one-cycle ops
    always_comb begin
        w_alu_res   = '0;
        w_alu_c     = 1'b0;
        w_alu_v     = 1'b0;
        w_op_single = 1'b1;
        case (w_opcode)
            OP_ADD: begin
                w_alu_res = w_sum[MSB:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            OP_SUB: begin
                w_alu_res = w_diff[MSB:0];
                w_alu_c   = w_diff[WIDTH];
                w_alu_v   = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
            end
            OP_AND: w_alu_res = r_a & r_b;
            OP_OR:  w_alu_res = r_a | r_b;
            OP_XOR: w_alu_res = r_a ^ r_b;
            OP_NOT: w_alu_res = ~r_a;
            OP_SHL: begin
                w_alu_res = {r_a[MSB-1:0], 1'b0};
                w_alu_c   = r_a[MSB];
            end
            OP_SHR: begin
                w_alu_res = {1'b0, r_a[MSB:1]};
                w_alu_c   = r_a[0];
            end
            default: w_op_single = 1'b0;
        endcase
    end

    assign w_op_mul = (w_opcode == OP_MUL);

    // ------------------------------------------------------------------
    // Iterative engine. r_acc holds {high partial product, multiplier};
    // each step adds A when the multiplier LSB is set and shifts right.
    // ------------------------------------------------------------------
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_step  = {w_mul_sum, r_acc[MSB:1]};
    assign w_calc_last = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef CALC_DIV_EN
    localparam logic [OP_W-1:0] OP_DIV = OP_W'(9);

    logic                   r_is_div;
    logic [WIDTH:0]         w_div_shift;
    logic [WIDTH:0]         w_div_trial;
    logic [2*WIDTH-1:0]     w_div_step;

    // For division r_acc holds {remainder, dividend/quotient}; shift the next
    // dividend bit into the remainder and keep the trial subtraction if it
    // does not borrow.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[MSB]};
    assign w_div_trial = w_div_shift - {1'b0, r_b};
    assign w_div_step  = w_div_trial[WIDTH]
                       ? {w_div_shift[MSB:0], r_acc[MSB-1:0], 1'b0}
                       : {w_div_trial[MSB:0], r_acc[MSB-1:0], 1'b1};

    assign w_op_div   = (w_opcode == OP_DIV);
    assign w_calc_div = r_is_div;
    assign w_acc_step = r_is_div ? w_div_step : w_mul_step;

    // Remember which iterative operation was launched
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_is_div <= 1'b0;
        end else if (w_clr_pulse) begin
            r_is_div <= 1'b0;
        end else if ((r_state == S_WITH_B) && w_ent_pulse) begin
            r_is_div <= w_op_div;
        end
    end
`else
    assign w_op_div   = 1'b0;
    assign w_calc_div = 1'b0;
    assign w_acc_step = w_mul_step;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state, Clear takes priority over a same-cycle Enter
    always_comb begin
        w_state_next = r_state;
        if (w_clr_pulse) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_ent_pulse) w_state_next = S_WITH_A;
                S_WITH_A: if (w_ent_pulse) w_state_next = S_WITH_B;
                S_WITH_B: begin
                    if (w_ent_pulse) begin
                        if (w_op_single) begin
                            w_state_next = S_RESULT;
                        end else if (w_op_mul) begin
                            w_state_next = S_CALC;
                        end else if (w_op_div) begin
                            w_state_next = (r_b == '0) ? S_ERROR : S_CALC;
                        end else begin
                            w_state_next = S_ERROR;
                        end
                    end
                end
                S_CALC:   if (w_calc_last) w_state_next = S_RESULT;
                S_RESULT: if (w_ent_pulse) w_state_next = S_WITH_A;
                S_ERROR:  w_state_next = S_ERROR;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    // FSM: state-decoded outputs (progress LEDs and busy)
    always_comb begin
        leds = 4'b0001;
        busy = 1'b0;
        case (r_state)
            S_IDLE:   leds = 4'b0001;
            S_WITH_A: leds = 4'b0011;
            S_WITH_B: leds = 4'b0111;
            S_CALC: begin
                leds = 4'b0111;
                busy = 1'b1;
            end
            S_RESULT: leds = 4'b1111;
            S_ERROR:  leds = 4'b1001;
            default:  leds = 4'b0001;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: operands, result, flags, iteration state
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a            <= '0;
            r_b            <= '0;
            r_result       <= '0;
            r_zero         <= 1'b0;
            r_carry        <= 1'b0;
            r_ovf          <= 1'b0;
            r_result_valid <= 1'b0;
            r_acc          <= '0;
            r_cnt          <= '0;
        end else begin
            // Pulse once on the first cycle spent in RESULT
            r_result_valid <= (w_state_next == S_RESULT) && (r_state != S_RESULT);
            if (w_clr_pulse) begin
                r_a      <= '0;
                r_b      <= '0;
                r_result <= '0;
                r_zero   <= 1'b0;
                r_carry  <= 1'b0;
                r_ovf    <= 1'b0;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_ent_pulse) r_a <= w_operand;
                    S_WITH_A: if (w_ent_pulse) r_b <= w_operand;
                    S_WITH_B: begin
                        if (w_ent_pulse) begin
                            r_cnt <= '0;
                            if (w_op_single) begin
                                r_result <= w_alu_res;
                                r_zero   <= (w_alu_res == '0);
                                r_carry  <= w_alu_c;
                                r_ovf    <= w_alu_v;
                            end else if (w_op_mul) begin
                                r_acc <= {{WIDTH{1'b0}}, r_b};
                            end else if (w_op_div) begin
                                r_acc <= {{WIDTH{1'b0}}, r_a};
                            end
                        end
                    end
                    S_CALC: begin
                        r_acc <= w_acc_step;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_calc_last) begin
                            r_result <= w_acc_step[MSB:0];
                            r_zero   <= (w_acc_step[MSB:0] == '0);
                            if (w_calc_div) begin
                                r_carry <= |w_acc_step[2*WIDTH-1:WIDTH];
                                r_ovf   <= 1'b0;
                            end else begin
                                r_carry <= 1'b0;
                                r_ovf   <= |w_acc_step[2*WIDTH-1:WIDTH];
                            end
                        end
                    end
                    S_RESULT: begin
                        if (w_ent_pulse) begin
                            r_a <= r_result;
                            r_b <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign a_q          = r_a;
    assign b_q          = r_b;
    assign result       = r_result;
    assign zero         = r_zero;
    assign carry        = r_carry;
    assign overflow     = r_ovf;
    assign result_valid = r_result_valid;
    assign state_q      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_calc_core_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_core_seq
// Description : Self-checking bench for calc_core_seq with a result
//               scoreboard; expected results are queued when the opcode is
//               entered and compared on each result_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_core_seq;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] switchs = '0;
    logic        enter   = 1'b0;
    logic        clear   = 1'b0;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [7:0]  result;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        busy;
    logic        result_valid;
    logic [2:0]  state_q;
    logic [3:0]  leds;

    int          total    = 0;
    int          bad      = 0;
    int          busy_cnt = 0;
    logic [31:0] sb[$];

    calc_core_seq #(
        .WIDTH      (8),
        .OP_W       (4),
        .SYNC_STAGES(2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .switchs     (switchs),
        .enter       (enter),
        .clear       (clear),
        .a_q         (a_q),
        .b_q         (b_q),
        .result      (result),
        .zero        (zero),
        .carry       (carry),
        .overflow    (overflow),
        .busy        (busy),
        .result_valid(result_valid),
        .state_q     (state_q),
        .leds        (leds)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_res(input logic z, input logic c, input logic v,
                                             input logic [7:0] r);
        return {21'b0, z, c, v, r};
    endfunction

    // Advance to the next falling edge and service the scoreboard
    task automatic tick();
        @(negedge clock);
        if (busy) busy_cnt++;
        if (reset_n && result_valid) begin
            if (sb.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else check("result", pack_res(zero, carry, overflow, result), sb.pop_front());
        end
    endtask

    task automatic press_enter(input logic [11:0] sw, input int hold, input int rel);
        switchs = sw;
        enter   = 1'b1;
        repeat (hold) tick();
        enter = 1'b0;
        repeat (rel) tick();
    endtask

    task automatic press_clear();
        clear = 1'b1;
        repeat (3) tick();
        clear = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_start;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        check("rst_state", 32'(state_q), 32'd0);
        check("rst_leds", 32'(leds), 32'b0001);
        check("rst_regs", {8'b0, a_q, b_q, result}, 32'd0);
        check("rst_flags", {27'b0, zero, carry, overflow, busy, result_valid}, 32'd0);

        // ADD 90 + 70 = 160: unsigned fits, signed overflows
        press_enter(12'h05A, 3, 3);
        check("add_a", 32'(a_q), 32'd90);
        press_enter(12'h046, 3, 3);
        sb.push_back(pack_res(1'b0, 1'b0, 1'b1, 8'hA0));
        press_enter(12'h000, 3, 3);
        check("add_state", 32'(state_q), 32'd4);
        check("add_leds", 32'(leds), 32'b1111);
        press_clear();

        // SUB 3 - 5 = 0xFE with borrow, then chain the result into A
        press_enter(12'h003, 3, 3);
        press_enter(12'h005, 3, 3);
        sb.push_back(pack_res(1'b0, 1'b1, 1'b0, 8'hFE));
        press_enter(12'h100, 3, 3);
        press_enter(12'h000, 3, 3);
        check("chain_ab", {16'b0, a_q, b_q}, {16'b0, 8'hFE, 8'h00});
        check("chain_state", 32'(state_q), 32'd1);
        check("chain_leds", 32'(leds), 32'b0011);
        press_clear();

        // AND giving zero
        press_enter(12'h00F, 3, 3);
        press_enter(12'h0F0, 3, 3);
        sb.push_back(pack_res(1'b1, 1'b0, 1'b0, 8'h00));
        press_enter(12'h200, 3, 3);
        press_clear();

        // SHL 0x81 -> 0x02, carry = old MSB
        press_enter(12'h081, 3, 3);
        press_enter(12'h000, 3, 3);
        sb.push_back(pack_res(1'b0, 1'b1, 1'b0, 8'h02));
        press_enter(12'h600, 3, 3);
        press_clear();

        // MUL 20 * 13 = 260: busy 8 cycles, Enter during busy ignored
        press_enter(12'h014, 3, 3);
        press_enter(12'h00D, 3, 3);
        busy_start = busy_cnt;
        sb.push_back(pack_res(1'b0, 1'b0, 1'b1, 8'h04));
        press_enter(12'h800, 3, 2);
        check("mul_calc", 32'(state_q), 32'd3);
        press_enter(12'h0FF, 3, 2);
        repeat (10) tick();
        check("mul_busy_cycles", 32'(busy_cnt - busy_start), 32'd8);
        check("mul_state", 32'(state_q), 32'd4);
        check("mul_ab", {16'b0, a_q, b_q}, {16'b0, 8'd20, 8'd13});
        press_clear();

        // Enter and Clear together in WITH_B
        press_enter(12'h011, 3, 3);
        press_enter(12'h022, 3, 3);
        check("wb_state", 32'(state_q), 32'd2);
        enter = 1'b1;
        clear = 1'b1;
        repeat (3) tick();
        enter = 1'b0;
        clear = 1'b0;
        repeat (3) tick();
        check("ec_state", 32'(state_q), 32'd0);
        check("ec_regs", {8'b0, a_q, b_q, result}, 32'd0);
        check("ec_leds", 32'(leds), 32'b0001);

        // Clear during a multiply aborts it
        press_enter(12'h014, 3, 3);
        press_enter(12'h00D, 3, 3);
        press_enter(12'h800, 3, 2);
        press_clear();
        check("abort_state", 32'(state_q), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (12) tick();
        check("abort_result", {24'b0, result}, 32'd0);

        // Unsupported opcode 0xF
        press_enter(12'h001, 3, 3);
        press_enter(12'h002, 3, 3);
        press_enter(12'hF00, 3, 3);
        check("err_state", 32'(state_q), 32'd5);
        check("err_leds", 32'(leds), 32'b1001);
        press_enter(12'h000, 3, 3);
        check("err_enter", 32'(state_q), 32'd5);
        press_clear();
        check("err_clear", 32'(state_q), 32'd0);

        // Opcode 9, 100 / 7
        press_enter(12'h064, 3, 3);
        press_enter(12'h007, 3, 3);
`ifdef CALC_DIV_EN
        sb.push_back(pack_res(1'b0, 1'b1, 1'b0, 8'd14));
        press_enter(12'h900, 3, 0);
        repeat (12) tick();
        check("div_state", 32'(state_q), 32'd4);
`else
        press_enter(12'h900, 3, 3);
        check("div_state", 32'(state_q), 32'd5);
`endif
        press_clear();
        // Opcode 9 with B = 0 is an error in either build
        press_enter(12'h064, 3, 3);
        press_enter(12'h000, 3, 3);
        press_enter(12'h900, 3, 3);
        check("div0_state", 32'(state_q), 32'd5);
        press_clear();

        // Held Enter: exactly one transition, at the third edge
        switchs = 12'h033;
        enter   = 1'b1;
        tick();
        check("hold_e1", 32'(state_q), 32'd0);
        tick();
        check("hold_e2", 32'(state_q), 32'd0);
        tick();
        check("hold_e3", 32'(state_q), 32'd1);
        repeat (50) tick();
        check("hold_end", 32'(state_q), 32'd1);
        check("hold_a", 32'(a_q), 32'h33);
        enter = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in the middle of CALC
        press_enter(12'h003, 3, 3);
        press_enter(12'h800, 3, 0);
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_state", 32'(state_q), 32'd0);
        check("arst_regs", {8'b0, a_q, b_q, result}, 32'd0);
        check("arst_outs", {26'b0, busy, result_valid, leds}, 32'b0001);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_core_seq.md
Name: calc_core_seq

Overview:
- Synchronous, parametrised calculator control and datapath core for the board-level calculator.
- Synchronises and edge-detects the Enter and Clear buttons, then sequences operand A, operand B and the opcode through an FSM.
- Runs single-cycle logic/add ops and a multi-cycle shift-add multiplier, and holds the result and flags for the BCD/display path.
- Generalises the previous Enter-clocked controller: width parameter, true clocked design with reset, multi-cycle ops, an error state and result-valid handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- OP_W, 4, opcode width in bits (>=4).
- SYNC_STAGES, 2, button synchroniser depth (>=2).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- switchs  in  OP_W+WIDTH  [WIDTH-1:0]=operand, [OP_W+WIDTH-1:WIDTH]=opcode.
- enter  in  1  raw Enter button, asynchronous, active-high.
- clear  in  1  raw Clear button, asynchronous, active-high.
- a_q  out  WIDTH  latched operand A.
- b_q  out  WIDTH  latched operand B.
- result  out  WIDTH  result register.
- zero  out  1  result==0, valid when result_valid.
- carry  out  1  carry/borrow/shift-out of last op.
- overflow  out  1  signed overflow (ADD/SUB) or truncated product (MUL).
- busy  out  1  multi-cycle op in progress.
- result_valid  out  1  one-cycle pulse when result/flags update.
- state_q  out  3  FSM state for display muxing.
- leds  out  4  progress LEDs.

Behaviour:
- Reset (reset_n low, async): state IDLE; a_q, b_q, result, flags, busy, result_valid = 0; leds = 4'b0001; synchronisers = 0.
- Button path: SYNC_STAGES-flop synchroniser, then edge register. Pulse = sync_out & ~edge_q.
  - Press held from before edge 1 gives the FSM update at edge SYNC_STAGES+1 (edge 3 at default).
  - A held button gives exactly one pulse.
- States (state_q encoding): IDLE=0, WITH_A=1, WITH_B=2, CALC=3, RESULT=4, ERROR=5.
- Clear pulse in any state: go to IDLE and zero a_q, b_q, result, flags, busy. Clear beats a same-cycle Enter. Clear in CALC aborts the multiply.
- Enter transitions:
  - IDLE: a_q <= operand; go to WITH_A.
  - WITH_A: b_q <= operand; go to WITH_B.
  - WITH_B: decode opcode.
    - Single-cycle op: result and flags written at that same edge; go to RESULT; result_valid pulses the following cycle.
    - MUL: go to CALC with busy=1.
    - Unsupported opcode: go to ERROR.
  - CALC: Enter ignored.
  - RESULT: chain. a_q <= result; b_q <= 0; go to WITH_A.
  - ERROR: Enter ignored; only Clear exits.
- Opcodes:
  - 0 ADD: carry = carry-out.
  - 1 SUB (A-B): carry = borrow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT A: carry=0, overflow=0.
  - 6 SHL A by 1: carry = A[MSB].
  - 7 SHR A by 1 (logical): carry = A[0].
  - 8 MUL: unsigned shift-add, exactly WIDTH cycles in CALC, then go to RESULT.
    - result = low WIDTH bits of the product; overflow = |(high WIDTH bits); carry=0.
  - 9 DIV: see Optional Feature. Any other opcode goes to ERROR.
- Overflow for ADD/SUB follows two's-complement sign rules. All arithmetic wraps modulo 2^WIDTH.
- zero is computed on the written result.
- result_valid: one-cycle pulse on the cycle after entering RESULT. Never asserted in ERROR.
- busy: high for every cycle in CALC, otherwise 0.
- leds by state: IDLE 0001, WITH_A 0011, WITH_B 0111, CALC 0111, RESULT 1111, ERROR 1001.

Optional Feature:
- Macro: CALC_DIV_EN.
- Defined: opcode 9 DIV is an unsigned restoring divider, WIDTH cycles in CALC.
  - result = quotient; carry = (remainder != 0).
  - B==0 goes to ERROR directly from WITH_B without entering CALC.
- Undefined: opcode 9 goes to ERROR like any unsupported opcode; no divider logic is synthesised.

Test Plan:
- Reset, then Enter with switchs=0x05A (op 0, A=90), Enter 0x046 (B=70), Enter op 0 -> result=160 (0xA0), carry=0, overflow=1, zero=0, one result_valid pulse, leds=1111.
- A=3, B=5, op 1 -> result=0xFE, carry=1, overflow=0; then Enter -> a_q=0xFE, b_q=0, state WITH_A, leds=0011.
- A=20, B=13, op 8 -> busy high exactly 8 cycles, result=0x04 (260 mod 256), overflow=1; Enter pulses during busy ignored.
- Enter and Clear raised in the same cycle while in WITH_B -> IDLE, all registers 0, leds=0001. Clear mid-MUL -> IDLE, busy=0, no result_valid.
- Opcode 0xF -> ERROR, leds=1001, Enter ignored, Clear -> IDLE. Opcode 9 without CALC_DIV_EN -> ERROR; with it, A=100, B=7 -> result=14, carry=1; B=0 -> ERROR.
- Enter held high 50 cycles -> exactly one transition, at edge 3 after assertion; reset_n pulsed low mid-CALC -> immediate async return to reset values.
